// File: rtl/if_id_queue_pkg.sv
// if_id_queue_pkg: widths and NOP encoding shared by the fetch/decode blocks.
package if_id_queue_pkg;
  localparam int ADDR_W = 16;
  localparam int INSTR_W = 16;
  localparam int DEPTH = 4;
  localparam logic [INSTR_W-1:0] NOP_INSTR = 16'h0000;
endpackage

// File: rtl/if_id_queue_storage.sv
// if_id_storage: DEPTH x W register array, one write port, async read port.
module if_id_storage #(
  parameter int DEPTH = 4,
  parameter int W = 32
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [W-1:0]             wdata,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [W-1:0]             rdata
);
  logic [DEPTH-1:0][W-1:0] mem_q, mem_d;
  always_comb begin
    mem_d = mem_q;
    if (we) mem_d[waddr] = wdata;
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) mem_q <= '0;
    else mem_q <= mem_d;
  assign rdata = mem_q[raddr];
endmodule

// File: rtl/if_id_queue.sv
// if_id_queue: fetch-to-decode FWFT queue with full-hold back-pressure and branch flush.
module if_id_queue
  import if_id_queue_pkg::*;
#(
  parameter int                       ADDR_W    = if_id_queue_pkg::ADDR_W,
  parameter int                       INSTR_W   = if_id_queue_pkg::INSTR_W,
  parameter int                       DEPTH     = if_id_queue_pkg::DEPTH,
  parameter logic [INSTR_W-1:0]       NOP_INSTR = if_id_queue_pkg::NOP_INSTR
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       fetch_valid,
  input  logic [ADDR_W-1:0]          fetch_pc,
  input  logic [INSTR_W-1:0]         fetch_instr,
  output logic                       fetch_hold,
  input  logic                       flush,
  input  logic                       dec_ready,
  output logic                       dec_valid,
  output logic [ADDR_W-1:0]          dec_pc,
  output logic [INSTR_W-1:0]         dec_instr,
  output logic [$clog2(DEPTH):0]     count,
  output logic [15:0]                hold_cycles
);
  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] FULL = (PW+1)'(DEPTH);
  logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [PW:0] count_q, count_d;
  logic [15:0] hold_cycles_q, hold_cycles_d;
  logic push, pop;
  logic [ADDR_W+INSTR_W-1:0] head;
  // hold depends only on registered count so fetch sees no combinational loop
  assign fetch_hold = count_q == FULL;
  assign dec_valid = count_q != '0;
  assign push = fetch_valid & ~fetch_hold & ~flush;
  assign pop = dec_ready & dec_valid & ~flush;
  always_comb begin
    wr_ptr_d = flush ? '0 : wr_ptr_q + PW'(push);
    rd_ptr_d = flush ? '0 : rd_ptr_q + PW'(pop);
    count_d = flush ? '0 : count_q + (PW+1)'(push) - (PW+1)'(pop);
    hold_cycles_d = (fetch_hold && hold_cycles_q != 16'hFFFF) ? hold_cycles_q + 16'd1 : hold_cycles_q;
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q <= '0;
      hold_cycles_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q <= count_d;
      hold_cycles_q <= hold_cycles_d;
    end
  if_id_storage #(.DEPTH(DEPTH), .W(ADDR_W+INSTR_W)) u_storage (
    .clk   (clk),
    .reset (reset),
    .we    (push),
    .waddr (wr_ptr_q),
    .wdata ({fetch_pc, fetch_instr}),
    .raddr (rd_ptr_q),
    .rdata (head)
  );
  assign dec_pc = dec_valid ? head[INSTR_W +: ADDR_W] : '0;
  assign dec_instr = dec_valid ? head[INSTR_W-1:0] : NOP_INSTR;
  assign count = count_q;
  assign hold_cycles = hold_cycles_q;
endmodule

// File: tb/tb_if_id_queue.sv
// tb_if_id_queue: table-driven vectors plus wrap and async-reset sequences.
module tb_if_id_queue;
  logic clk = 1'b0;
  logic reset = 1'b0;
  logic fetch_valid = 1'b0, flush = 1'b0, dec_ready = 1'b0;
  logic [15:0] fetch_pc = '0, fetch_instr = '0;
  logic fetch_hold, dec_valid;
  logic [15:0] dec_pc, dec_instr, hold_cycles;
  logic [2:0] count;
  int checks = 0, errors = 0;

  always #5 clk = ~clk;

  if_id_queue dut (
    .clk(clk), .reset(reset), .fetch_valid(fetch_valid), .fetch_pc(fetch_pc),
    .fetch_instr(fetch_instr), .fetch_hold(fetch_hold), .flush(flush),
    .dec_ready(dec_ready), .dec_valid(dec_valid), .dec_pc(dec_pc),
    .dec_instr(dec_instr), .count(count), .hold_cycles(hold_cycles)
  );

  typedef struct {
    logic fv; logic [15:0] pc; logic [15:0] ins; logic fl; logic dr;
    logic ev; logic [15:0] epc; logic [15:0] eins; logic [2:0] ecnt; logic eh; logic [15:0] ehc;
  } vec_t;

  vec_t tbl[25];

  function automatic vec_t mk(logic fv, logic [15:0] pc, logic [15:0] ins, logic fl, logic dr,
                              logic ev, logic [15:0] epc, logic [15:0] eins, logic [2:0] ecnt,
                              logic eh, logic [15:0] ehc);
    vec_t r;
    r.fv = fv; r.pc = pc; r.ins = ins; r.fl = fl; r.dr = dr;
    r.ev = ev; r.epc = epc; r.eins = eins; r.ecnt = ecnt; r.eh = eh; r.ehc = ehc;
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic ev, input logic [15:0] epc, input logic [15:0] eins,
                         input logic [2:0] ecnt, input logic eh);
    chk({tag, ".dec_valid"}, 32'(dec_valid), 32'(ev));
    chk({tag, ".dec_pc"}, 32'(dec_pc), 32'(epc));
    chk({tag, ".dec_instr"}, 32'(dec_instr), 32'(eins));
    chk({tag, ".count"}, 32'(count), 32'(ecnt));
    chk({tag, ".fetch_hold"}, 32'(fetch_hold), 32'(eh));
  endtask

  task automatic drive(input logic fv, input logic [15:0] pc, input logic [15:0] ins, input logic fl, input logic dr);
    @(negedge clk);
    fetch_valid = fv; fetch_pc = pc; fetch_instr = ins; flush = fl; dec_ready = dr;
    @(posedge clk);
    #1;
  endtask

  initial begin
    //               fv  pc       ins      fl dr   ev epc      eins     cnt h  hc
    tbl[0]  = mk(0, 16'h0000, 16'h0000, 0, 0,  0, 16'h0000, 16'h0000, 0, 0, 0);
    tbl[1]  = mk(1, 16'h0000, 16'h1234, 0, 0,  1, 16'h0000, 16'h1234, 1, 0, 0);
    tbl[2]  = mk(1, 16'h0002, 16'h5678, 0, 0,  1, 16'h0000, 16'h1234, 2, 0, 0);
    tbl[3]  = mk(0, 16'h0000, 16'h0000, 0, 1,  1, 16'h0002, 16'h5678, 1, 0, 0);
    tbl[4]  = mk(0, 16'h0000, 16'h0000, 0, 1,  0, 16'h0000, 16'h0000, 0, 0, 0);
    tbl[5]  = mk(0, 16'h0000, 16'h0000, 0, 1,  0, 16'h0000, 16'h0000, 0, 0, 0);
    tbl[6]  = mk(1, 16'h0010, 16'hA001, 0, 0,  1, 16'h0010, 16'hA001, 1, 0, 0);
    tbl[7]  = mk(1, 16'h0012, 16'hA002, 0, 0,  1, 16'h0010, 16'hA001, 2, 0, 0);
    tbl[8]  = mk(1, 16'h0014, 16'hA003, 0, 0,  1, 16'h0010, 16'hA001, 3, 0, 0);
    tbl[9]  = mk(1, 16'h0016, 16'hA004, 0, 0,  1, 16'h0010, 16'hA001, 4, 1, 0);
    tbl[10] = mk(1, 16'h0018, 16'hA005, 0, 0,  1, 16'h0010, 16'hA001, 4, 1, 1);
    tbl[11] = mk(1, 16'h0018, 16'hA005, 0, 0,  1, 16'h0010, 16'hA001, 4, 1, 2);
    tbl[12] = mk(1, 16'h0018, 16'hA005, 0, 0,  1, 16'h0010, 16'hA001, 4, 1, 3);
    tbl[13] = mk(1, 16'h0018, 16'hA005, 0, 1,  1, 16'h0012, 16'hA002, 3, 0, 4);
    tbl[14] = mk(1, 16'h0018, 16'hA005, 0, 0,  1, 16'h0012, 16'hA002, 4, 1, 4);
    tbl[15] = mk(0, 16'h0000, 16'h0000, 0, 1,  1, 16'h0014, 16'hA003, 3, 0, 5);
    tbl[16] = mk(0, 16'h0000, 16'h0000, 0, 1,  1, 16'h0016, 16'hA004, 2, 0, 5);
    tbl[17] = mk(0, 16'h0000, 16'h0000, 0, 1,  1, 16'h0018, 16'hA005, 1, 0, 5);
    tbl[18] = mk(0, 16'h0000, 16'h0000, 0, 1,  0, 16'h0000, 16'h0000, 0, 0, 5);
    tbl[19] = mk(1, 16'h0020, 16'hB001, 0, 0,  1, 16'h0020, 16'hB001, 1, 0, 5);
    tbl[20] = mk(1, 16'h0022, 16'hB002, 0, 0,  1, 16'h0020, 16'hB001, 2, 0, 5);
    tbl[21] = mk(1, 16'h0024, 16'hB003, 0, 0,  1, 16'h0020, 16'hB001, 3, 0, 5);
    tbl[22] = mk(1, 16'h0026, 16'hB004, 1, 1,  0, 16'h0000, 16'h0000, 0, 0, 5);
    tbl[23] = mk(1, 16'h0030, 16'hC001, 0, 0,  1, 16'h0030, 16'hC001, 1, 0, 5);
    tbl[24] = mk(0, 16'h0000, 16'h0000, 0, 1,  0, 16'h0000, 16'h0000, 0, 0, 5);

    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < 25; i++) begin
      drive(tbl[i].fv, tbl[i].pc, tbl[i].ins, tbl[i].fl, tbl[i].dr);
      chk_out($sformatf("vec%0d", i), tbl[i].ev, tbl[i].epc, tbl[i].eins, tbl[i].ecnt, tbl[i].eh);
      chk($sformatf("vec%0d.hold_cycles", i), 32'(hold_cycles), 32'(tbl[i].ehc));
    end

    // streaming push+pop across pointer wrap: head must always be the newest pair
    drive(1, 16'h0100, 16'hD000, 0, 0);
    chk_out("wrap0", 1, 16'h0100, 16'hD000, 1, 0);
    for (int i = 1; i <= 10; i++) begin
      drive(1, 16'h0100 + 16'(2 * i), 16'hD000 + 16'(i), 0, 1);
      chk_out($sformatf("wrap%0d", i), 1, 16'h0100 + 16'(2 * i), 16'hD000 + 16'(i), 1, 0);
    end
    drive(0, 16'h0000, 16'h0000, 0, 1);
    chk_out("drain", 0, 16'h0000, 16'h0000, 0, 0);

    // async reset between edges with three entries buffered
    drive(1, 16'h0200, 16'hE001, 0, 0);
    drive(1, 16'h0202, 16'hE002, 0, 0);
    drive(1, 16'h0204, 16'hE003, 0, 0);
    fetch_valid = 1'b0;
    chk("pre_rst.count", 32'(count), 32'd3);
    #2;
    reset = 1'b0;
    #1;
    chk_out("async_rst", 0, 16'h0000, 16'h0000, 0, 0);
    chk("async_rst.hold_cycles", 32'(hold_cycles), 32'd0);
    @(negedge clk);
    reset = 1'b1;
    drive(1, 16'h0300, 16'hF001, 0, 0);
    chk_out("post_rst", 1, 16'h0300, 16'hF001, 1, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/if_id_queue.md
Name: if_id_queue

Overview:
- Decode-side receiver for the fetch stage: accepts {pc, instruction} pairs each cycle from fetch (PC register plus instruction memory read) and buffers them in a small FIFO.
- Presents them first-word-fall-through to decode with a valid/ready handshake.
- Drives a hold signal back to fetch that freezes PC advance (the hazard-mux control) when full.
- Discards all buffered entries on a branch-taken flush.

Parameters:
- ADDR_W, 16, PC width in bits.
- INSTR_W, 16, instruction width in bits.
- DEPTH, 4, number of entries; must be a power of two and at least 2.
- NOP_INSTR, 16'h0000, value driven on dec_instr when the queue is empty.

Ports:
- clk  input  1  single system clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-low reset (0 = reset asserted).
- fetch_valid  input  1  fetch is presenting a pair this cycle.
- fetch_pc  input  ADDR_W  PC of the presented instruction.
- fetch_instr  input  INSTR_W  instruction memory read data for fetch_pc.
- fetch_hold  output  1  1 = queue full; fetch must keep PC and re-present the same pair.
- flush  input  1  branch taken; discard every entry and the same-cycle push.
- dec_ready  input  1  decode consumes the head entry this cycle.
- dec_valid  output  1  head entry is valid.
- dec_pc  output  ADDR_W  PC of the head entry.
- dec_instr  output  INSTR_W  instruction of the head entry; NOP_INSTR when empty.
- count  output  log2(DEPTH)+1  number of valid entries, 0..DEPTH.
- hold_cycles  output  16  saturating count of cycles with fetch_hold=1.

Behaviour:
- Reset (reset=0, asynchronous):
  - wr_ptr=0, rd_ptr=0, count=0, hold_cycles=0, all storage=0.
  - dec_valid=0, dec_pc=0, dec_instr=NOP_INSTR, fetch_hold=0.
- Combinational outputs:
  - fetch_hold = (count==DEPTH), from registered count only; no combinational path from the fetch_* or dec_* inputs.
  - dec_valid = (count!=0).
  - dec_pc/dec_instr = storage[rd_ptr] when count!=0, else 0/NOP_INSTR.
- Handshakes:
  - push = fetch_valid & ~fetch_hold & ~flush.
  - pop = dec_ready & dec_valid & ~flush.
  - Write: storage[wr_ptr] <= {fetch_pc, fetch_instr}; wr_ptr increments modulo DEPTH.
  - Read: rd_ptr increments modulo DEPTH.
- count update: push only +1; pop only -1; push and pop together, count unchanged and both pointers advance.
- Full boundary:
  - With count==DEPTH a push is refused even if pop occurs the same cycle.
  - Fetch re-presents the pair next cycle with hold=0; nothing is lost or duplicated.
- Empty boundary:
  - Push at count==0 makes the entry visible on dec_* the next cycle (one-cycle latency, no bypass).
  - dec_ready while empty has no effect.
- Flush (registered, synchronous):
  - Next edge: count=0, rd_ptr=wr_ptr=0. Storage is not cleared.
  - The same-cycle push and pop are both ignored.
  - flush has priority over every other event.
- hold_cycles: increments on every edge where fetch_hold=1; saturates at 16'hFFFF; cleared only by reset.
- Reset mid-operation: immediate return to the reset state regardless of clock; pending pairs are dropped.
- Pointer wrap: pointers are log2(DEPTH) bits and wrap naturally. Full/empty is decided by count, never by pointer compare.

Decomposition:
- Shared package holds ADDR_W, INSTR_W and NOP_INSTR so the pc, pc_mux, adder and decode blocks agree on widths.
- One natural sub-module: if_id_storage, a DEPTH x (ADDR_W+INSTR_W) register array with a write port, write enable and asynchronous read port.
- Pointers, count, flush and hold logic stay in if_id_queue.

Test Plan:
- Reset then idle → dec_valid=0, dec_instr=16'h0000, fetch_hold=0, count=0.
- Push pc=0x0000/0x1234, pc=0x0002/0x5678 with dec_ready=0 → count=2; dec_pc=0x0000, dec_instr=0x1234; one pop → dec_pc=0x0002, dec_instr=0x5678.
- Push 4 entries with dec_ready=0 → fetch_hold=1, count=4. Hold fetch_valid=1 for 3 cycles → hold_cycles=3, no overwrite. Pop once → hold=0; re-presented pair accepted as 5th in order.
- Queue at count=3; assert flush with fetch_valid=1 and dec_ready=1 the same cycle → next cycle count=0, dec_valid=0; the next push appears at head.
- Continuous push and pop with dec_ready=1 over 10 pairs (pointer wrap) → output order equals input order, count stays 1, fetch_hold never set.
- Drop reset to 0 asynchronously between edges with count=3 → count=0 and dec_valid=0 immediately.
